// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin arbiter sharing one CORDIC pipeline between NUM_CH channels, with tag tracking and flush.
// Optional per-channel saturating grant counters are built when CORDIC_ARB_STATS_EN is defined.
module cordic_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int LATENCY = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     req_valid,
    input  logic [NUM_CH*32-1:0]  req_re,
    input  logic [NUM_CH*32-1:0]  req_im,
    output logic [NUM_CH-1:0]     req_ready,
    output logic                  cord_enable,
    output logic [31:0]           cord_x_re,
    output logic [31:0]           cord_x_im,
    input  logic                  cord_enable_out,
    input  logic [31:0]           cord_theta,
    input  logic [31:0]           cord_mag,
    output logic                  res_valid,
    output logic [2:0]            res_ch,
    output logic [31:0]           res_theta,
    output logic [31:0]           res_mag,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  tag_err,
    input  logic [2:0]            stat_sel,
    output logic [15:0]           stat_cnt
);

    localparam int IFW = $clog2(LATENCY + 2);
    localparam int WCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'b00,
        ST_RUN    = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [WCW-1:0]         warm_cnt_r;
    logic [2:0]             ptr_r;
    logic [IFW-1:0]         inflight_r;
    logic [IFW-1:0]         inflight_s;

    logic [2*NUM_CH-1:0]    rot_s;
    logic                   eligible_s;
    logic                   hs_s;
    logic [2:0]             grant_idx_s;
    logic [NUM_CH-1:0]      grant_s;
    logic [31:0]            op_re_s;
    logic [31:0]            op_im_s;

    logic                   cord_enable_r;
    logic [2:0]             cord_ch_r;
    logic [31:0]            cord_x_re_r;
    logic [31:0]            cord_x_im_r;

    logic [LATENCY-1:0]     tag_vld_r;
    logic [2:0]             tag_ch_r [LATENCY];
    logic                   tag_out_vld_s;
    logic                   tag_err_r;

    function automatic logic [2:0] wrap_idx(input logic [2:0] p, input int k);
        int s;
        s = int'(p) + k;
        return (s >= NUM_CH) ? 3'(s - NUM_CH) : 3'(s);
    endfunction

    // Round-robin scan: first valid channel at or after ptr; lowest offset wins.
    always_comb begin
        logic hit_v;
        hit_v       = 1'b0;
        eligible_s  = (state_r == ST_RUN) && !flush;
        rot_s       = {req_valid, req_valid} >> ptr_r;
        hs_s        = 1'b0;
        grant_idx_s = 3'd0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            hit_v       = eligible_s & rot_s[k];
            grant_idx_s = hit_v ? wrap_idx(ptr_r, k) : grant_idx_s;
            hs_s        = hs_s | hit_v;
        end
        grant_s = hs_s ? (NUM_CH'(1) << grant_idx_s) : {NUM_CH{1'b0}};
    end

    // Operand mux for the granted channel.
    always_comb begin
        op_re_s = 32'h0000_0000;
        op_im_s = 32'h0000_0000;
        for (int k = 0; k < NUM_CH; k++) begin
            op_re_s = (grant_idx_s == 3'(k)) ? req_re[k*32 +: 32] : op_re_s;
            op_im_s = (grant_idx_s == 3'(k)) ? req_im[k*32 +: 32] : op_im_s;
        end
    end

    // In-flight bookkeeping: an item counts from CORDIC issue until its tag leaves the shift register.
    always_comb begin
        inflight_s = inflight_r;
        case ({cord_enable_r, tag_out_vld_s})
            2'b10:   inflight_s = inflight_r + IFW'(1);
            2'b01:   inflight_s = inflight_r - IFW'(1);
            default: inflight_s = inflight_r;
        endcase
    end

    // Next-state logic; DRAIN looks at the post-retire count so DONE follows the last result directly.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_WARMUP: state_s = (warm_cnt_r == WCW'(LATENCY - 1)) ? ST_RUN : ST_WARMUP;
            ST_RUN:    state_s = flush ? ST_DRAIN : ST_RUN;
            ST_DRAIN:  state_s = (inflight_s == {IFW{1'b0}}) ? ST_DONE : ST_DRAIN;
            ST_DONE:   state_s = flush ? ST_DONE : ST_RUN;
            default:   state_s = ST_WARMUP;
        endcase
    end

    // State, warm-up counter, pointer and in-flight count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_WARMUP;
            warm_cnt_r <= {WCW{1'b0}};
            ptr_r      <= 3'd0;
            inflight_r <= {IFW{1'b0}};
        end else begin
            state_r    <= state_s;
            warm_cnt_r <= (state_r == ST_WARMUP) ? warm_cnt_r + WCW'(1) : {WCW{1'b0}};
            if (hs_s) begin
                ptr_r <= (grant_idx_s == 3'(NUM_CH - 1)) ? 3'd0 : grant_idx_s + 3'd1;
            end
            inflight_r <= inflight_s;
        end
    end

    // Registered CORDIC drive; operands hold between grants.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cord_enable_r <= 1'b0;
            cord_ch_r     <= 3'd0;
            cord_x_re_r   <= 32'h0000_0000;
            cord_x_im_r   <= 32'h0000_0000;
        end else begin
            cord_enable_r <= hs_s;
            if (hs_s) begin
                cord_ch_r   <= grant_idx_s;
                cord_x_re_r <= op_re_s;
                cord_x_im_r <= op_im_s;
            end
        end
    end

    // Tag shift register follows the CORDIC enable through the pipeline.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_vld_r <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                tag_ch_r[i] <= 3'd0;
            end
        end else begin
            tag_vld_r[0] <= cord_enable_r;
            tag_ch_r[0]  <= cord_ch_r;
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_ch_r[i]  <= tag_ch_r[i-1];
            end
        end
    end

    assign tag_out_vld_s = tag_vld_r[LATENCY-1];

    // Sticky tag/pipeline disagreement flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_err_r <= 1'b0;
        end else if (cord_enable_out != tag_out_vld_s) begin
            tag_err_r <= 1'b1;
        end
    end

`ifdef CORDIC_ARB_STATS_EN
    logic [15:0] grant_cnt_r [NUM_CH];
    logic [15:0] stat_cnt_r;

    // Saturating per-channel grant counters and registered readout.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                grant_cnt_r[k] <= 16'h0000;
            end
            stat_cnt_r <= 16'h0000;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (hs_s && (grant_idx_s == 3'(k)) && (grant_cnt_r[k] != 16'hFFFF)) begin
                    grant_cnt_r[k] <= grant_cnt_r[k] + 16'h0001;
                end
            end
            stat_cnt_r <= 16'h0000;
            for (int k = 0; k < NUM_CH; k++) begin
                if (stat_sel == 3'(k)) begin
                    stat_cnt_r <= grant_cnt_r[k];
                end
            end
        end
    end

    assign stat_cnt = stat_cnt_r;
`else
    logic unused_stat_sel_s;
    assign unused_stat_sel_s = ^stat_sel;
    assign stat_cnt          = 16'h0000;
`endif

    assign req_ready   = grant_s;
    assign cord_enable = cord_enable_r;
    assign cord_x_re   = cord_x_re_r;
    assign cord_x_im   = cord_x_im_r;
    assign res_valid   = tag_out_vld_s;
    assign res_ch      = tag_ch_r[LATENCY-1];
    assign res_theta   = cord_theta;
    assign res_mag     = cord_mag;
    assign flush_done  = (state_r == ST_DONE);
    assign tag_err     = tag_err_r;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench for cordic_arbiter: a behavioural CORDIC stand-in plus a scoreboard reference model.
// Expected statistics follow the CORDIC_ARB_STATS_EN build setting.
module tb_cordic_arbiter;

    localparam int LAT = 5;
    localparam logic [31:0] TH_KEY = 32'hA5A5_5A5A;
`ifdef CORDIC_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int PH_WARM  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_DRAIN = 2;
    localparam int PH_DONE  = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_re, req_im;
    logic [3:0]   req_ready;
    logic         cord_enable;
    logic [31:0]  cord_x_re, cord_x_im;
    logic         cord_enable_out;
    logic [31:0]  cord_theta, cord_mag;
    logic         res_valid;
    logic [2:0]   res_ch;
    logic [31:0]  res_theta, res_mag;
    logic         flush, flush_done, tag_err;
    logic [2:0]   stat_sel;
    logic [15:0]  stat_cnt;
    logic         force_eo;
    logic         fixed_op;

    cordic_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_re(req_re), .req_im(req_im),
        .req_ready(req_ready), .cord_enable(cord_enable), .cord_x_re(cord_x_re), .cord_x_im(cord_x_im),
        .cord_enable_out(cord_enable_out), .cord_theta(cord_theta), .cord_mag(cord_mag),
        .res_valid(res_valid), .res_ch(res_ch), .res_theta(res_theta), .res_mag(res_mag),
        .flush(flush), .flush_done(flush_done), .tag_err(tag_err),
        .stat_sel(stat_sel), .stat_cnt(stat_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in CORDIC: fixed LAT-cycle pipe with easily predicted outputs.
    logic        pe [LAT];
    logic [31:0] pt [LAT];
    logic [31:0] pm [LAT];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                pe[i] <= 1'b0; pt[i] <= 32'h0; pm[i] <= 32'h0;
            end
        end else begin
            pe[0] <= cord_enable;
            pt[0] <= cord_x_re ^ TH_KEY;
            pm[0] <= cord_x_re + cord_x_im;
            for (int i = 1; i < LAT; i++) begin
                pe[i] <= pe[i-1]; pt[i] <= pt[i-1]; pm[i] <= pm[i-1];
            end
        end
    end
    assign cord_enable_out = pe[LAT-1] | force_eo;
    assign cord_theta      = pt[LAT-1];
    assign cord_mag        = pm[LAT-1];

    typedef struct {
        int          due;
        int          ch;
        logic [31:0] re;
        logic [31:0] im;
    } exp_t;

    exp_t        sb[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          ph, mwarm, mptr;
    int          gcnt [4];
    logic        prev_hs;
    logic [31:0] last_re, last_im;
    logic        exp_tagerr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_reset(input logic [3:0] rv);
        @(negedge clk);
        reset = 1'b0; req_valid = rv; flush = 1'b0; force_eo = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_cord_enable", 32'(cord_enable), 32'h0);
        chk("rst_x_re", cord_x_re, 32'h0);
        chk("rst_x_im", cord_x_im, 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_res_ch", 32'(res_ch), 32'h0);
        chk("rst_flush_done", 32'(flush_done), 32'h0);
        chk("rst_tag_err", 32'(tag_err), 32'h0);
        chk("rst_stat_cnt", 32'(stat_cnt), 32'h0);
        reset = 1'b1;
        ph = PH_WARM; mwarm = 1; mptr = 0; sb.delete(); prev_hs = 1'b0;
        last_re = 32'h0; last_im = 32'h0; exp_tagerr = 1'b0;
        for (int c = 0; c < 4; c++) gcnt[c] = 0;
        cyc++;
    endtask

    // One clock of stimulus plus full comparison against the reference model.
    task automatic cycle(input logic [3:0] rv, input logic fl, input logic fe, output int g);
        logic [3:0] exp_ready;
        logic       exp_rv;
        exp_t       e;
        @(negedge clk);
        req_valid = rv; flush = fl; force_eo = fe;
        for (int c = 0; c < 4; c++) begin
            req_re[c*32 +: 32] = $urandom;
            req_im[c*32 +: 32] = $urandom;
        end
        if (fixed_op) begin
            req_re[64 +: 32] = 32'h0100_0000;
            req_im[64 +: 32] = 32'h0000_0000;
        end
        #1;
        g = -1;
        if (ph == PH_RUN && !fl) begin
            for (int k = 3; k >= 0; k--) begin
                if (rv[(mptr + k) % 4]) g = (mptr + k) % 4;
            end
        end
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("cord_enable", 32'(cord_enable), 32'(prev_hs));
        chk("cord_x_re", cord_x_re, last_re);
        chk("cord_x_im", cord_x_im, last_im);
        exp_rv = (sb.size() > 0) && (sb[0].due == cyc);
        chk("res_valid", 32'(res_valid), 32'(exp_rv));
        if (exp_rv) begin
            chk("res_ch", 32'(res_ch), 32'(sb[0].ch));
            chk("res_theta", res_theta, sb[0].re ^ TH_KEY);
            chk("res_mag", res_mag, sb[0].re + sb[0].im);
            void'(sb.pop_front());
        end
        chk("flush_done", 32'(flush_done), 32'(ph == PH_DONE));
        chk("tag_err", 32'(tag_err), 32'(exp_tagerr));
        if (cord_enable_out !== exp_rv) exp_tagerr = 1'b1;
        if (g >= 0) begin
            e.due = cyc + LAT + 1; e.ch = g;
            e.re = req_re[g*32 +: 32]; e.im = req_im[g*32 +: 32];
            sb.push_back(e);
            mptr = (g + 1) % 4;
            gcnt[g]++;
            last_re = e.re; last_im = e.im;
        end
        prev_hs = (g >= 0);
        case (ph)
            PH_WARM:  begin mwarm++; if (mwarm == LAT) ph = PH_RUN; end
            PH_RUN:   if (fl) ph = PH_DRAIN;
            PH_DRAIN: if (sb.size() == 0) ph = PH_DONE;
            PH_DONE:  if (!fl) ph = PH_RUN;
            default:  ph = PH_WARM;
        endcase
        cyc++;
    endtask

    initial begin
        int g;
        int ord [5];
        logic [31:0] exp_stat;
        ord = '{0, 1, 2, 3, 0};
        reset = 1'b0; req_valid = 4'h0; req_re = '0; req_im = '0;
        flush = 1'b0; force_eo = 1'b0; fixed_op = 1'b0; stat_sel = 3'd0;

        // Warm-up then round-robin with everyone requesting.
        do_reset(4'hF);
        for (int i = 0; i < 4; i++) begin
            cycle(4'hF, 1'b0, 1'b0, g);
            chk("warmup_no_grant", 32'(g), 32'hFFFF_FFFF);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(4'hF, 1'b0, 1'b0, g);
            chk("rr_order", 32'(g), 32'(ord[i]));
        end

        // Pointer at 1 with only ch0/ch3 requesting.
        cycle(4'b1001, 1'b0, 1'b0, g); chk("ptr1_first", 32'(g), 32'd3);
        cycle(4'b1001, 1'b0, 1'b0, g); chk("ptr1_second", 32'(g), 32'd0);
        cycle(4'hF, 1'b0, 1'b0, g);    chk("ptr_after_wrap", 32'(g), 32'd1);
        repeat (8) cycle(4'h0, 1'b0, 1'b0, g);

        // Single ch2 request with a fixed operand; result tagged six cycles later.
        fixed_op = 1'b1;
        cycle(4'b0100, 1'b0, 1'b0, g); chk("single_ch2", 32'(g), 32'd2);
        fixed_op = 1'b0;
        repeat (8) cycle(4'h0, 1'b0, 1'b0, g);

        // Random request patterns.
        repeat (400) cycle(4'($urandom), 1'b0, 1'b0, g);
        repeat (8) cycle(4'h0, 1'b0, 1'b0, g);

        // Flush with three results in flight.
        cycle(4'b0001, 1'b0, 1'b0, g); chk("pre_flush_0", 32'(g), 32'd0);
        cycle(4'b0010, 1'b0, 1'b0, g); chk("pre_flush_1", 32'(g), 32'd1);
        cycle(4'b0100, 1'b0, 1'b0, g); chk("pre_flush_2", 32'(g), 32'd2);
        for (int i = 0; i < 9; i++) begin
            cycle(4'hF, 1'b1, 1'b0, g);
            chk("flush_no_grant", 32'(g), 32'hFFFF_FFFF);
        end
        cycle(4'hF, 1'b0, 1'b0, g); chk("done_no_grant", 32'(g), 32'hFFFF_FFFF);
        cycle(4'hF, 1'b0, 1'b0, g); chk("grant_after_flush", 32'(g >= 0), 32'd1);

        // Flush released early: drain and a single DONE cycle still happen.
        cycle(4'hF, 1'b0, 1'b0, g);
        cycle(4'hF, 1'b1, 1'b0, g);
        repeat (12) cycle(4'hF, 1'b0, 1'b0, g);
        repeat (8) cycle(4'h0, 1'b0, 1'b0, g);

        // Spurious CORDIC enable with nothing in flight.
        cycle(4'h0, 1'b0, 1'b1, g);
        repeat (4) cycle(4'h0, 1'b0, 1'b0, g);
        chk("tag_err_sticky", 32'(tag_err), 32'd1);

        // Reset with work in flight: nothing from before the reset may return.
        repeat (3) cycle(4'hF, 1'b0, 1'b0, g);
        do_reset(4'h0);
        repeat (12) cycle(4'h0, 1'b0, 1'b0, g);

        // Long single-channel run for counter saturation.
        repeat (70000) cycle(4'b0010, 1'b0, 1'b0, g);
        repeat (8) cycle(4'h0, 1'b0, 1'b0, g);
        for (int s = 0; s < 8; s++) begin
            stat_sel = 3'(s);
            repeat (2) cycle(4'h0, 1'b0, 1'b0, g);
            exp_stat = (STATS && s < 4) ? 32'((gcnt[s] > 65535) ? 65535 : gcnt[s]) : 32'h0;
            chk("stat_cnt", 32'(stat_cnt), exp_stat);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
